// File: rtl/dmem_bridge_if.sv
// Core-side data-memory bus between the RV32I MEM stage (master) and dmem_bridge (slave).
interface dmem_bridge_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] dAddress;
   logic [31:0] dWriteData;
   logic [31:0] dReadData;
   logic        mem_ready;
   logic        mem_err;

   modport master (
      output MemRead, MemWrite, dAddress, dWriteData,
      input  dReadData, mem_ready, mem_err
   );

   modport slave (
      input  MemRead, MemWrite, dAddress, dWriteData,
      output dReadData, mem_ready, mem_err
   );
endinterface

// File: rtl/dmem_bridge.sv
// Data-memory bridge: decodes core strobes into RAM / MMIO / unmapped space and runs one access per request.
// Define DMEM_MMIO_EN to build the MMIO window (LED register at +0, cycle counter at +4).
module dmem_bridge #(
   parameter logic [31:0] RAM_BASE    = 32'h1001_0000,
   parameter int          RAM_WORDS   = 1024,
   parameter int          RAM_LATENCY = 2,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic                         clk,
   input  logic                         rst,
   dmem_bridge_if.slave                 bus,
   output logic                         ram_en,
   output logic                         ram_we,
   output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
   output logic [31:0]                  ram_wdata,
   input  logic [31:0]                  ram_rdata,
   output logic [31:0]                  led_out
);

   localparam int          AW     = $clog2(RAM_WORDS);
   localparam logic [3:0]  LAT_M1 = 4'(RAM_LATENCY - 1);
   localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
   localparam logic [32:0] RAM_HI = RAM_LO + (33'(RAM_WORDS) << 2);
`ifdef DMEM_MMIO_EN
   localparam bit          MMIO_ON = 1'b1;
`else
   localparam bit          MMIO_ON = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t        state;
   logic [3:0]    wait_cnt;
   logic          req;
   logic          hit_ram;
   logic          hit_led;
   logic          hit_cnt;
   logic          req_bad;
   logic [AW-1:0] ram_word;
   logic [31:0]   mmio_rdata;

   // 33-bit compare keeps the RAM window from wrapping past 32'hFFFFFFFF.
   assign req      = bus.MemRead || bus.MemWrite;
   assign hit_ram  = ({1'b0, bus.dAddress} >= RAM_LO) && ({1'b0, bus.dAddress} < RAM_HI);
   assign hit_led  = MMIO_ON && (bus.dAddress == MMIO_BASE);
   assign hit_cnt  = MMIO_ON && (bus.dAddress == MMIO_BASE + 32'd4);
   assign req_bad  = (bus.MemRead && bus.MemWrite) || (bus.dAddress[1:0] != 2'b00)
                     || !(hit_ram || hit_led || hit_cnt);
   assign ram_word = AW'((bus.dAddress - RAM_BASE) >> 2);

`ifdef DMEM_MMIO_EN
   logic [31:0] led_reg;
   logic [31:0] cycle_count;

   always_ff @(posedge clk) begin
      if (rst) cycle_count <= '0;
      else     cycle_count <= cycle_count + 32'd1;
   end

   assign mmio_rdata = hit_cnt ? cycle_count : led_reg;
   assign led_out    = led_reg;
`else
   assign mmio_rdata = '0;
   assign led_out    = '0;
`endif

   // Everything the bridge presents is registered here; pulses default low each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         wait_cnt      <= '0;
         ram_en        <= 1'b0;
         ram_we        <= 1'b0;
         ram_addr      <= '0;
         ram_wdata     <= '0;
         bus.dReadData <= '0;
         bus.mem_ready <= 1'b0;
         bus.mem_err   <= 1'b0;
`ifdef DMEM_MMIO_EN
         led_reg       <= '0;
`endif
      end else begin
         ram_en        <= 1'b0;
         bus.mem_ready <= 1'b0;
         bus.mem_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (req_bad) begin
                     state         <= DONE;
                     bus.mem_ready <= 1'b1;
                     bus.mem_err   <= 1'b1;
                     if (bus.MemRead) bus.dReadData <= '0;
                  end else if (hit_ram) begin
                     state     <= ISSUE;
                     ram_en    <= 1'b1;
                     ram_we    <= bus.MemWrite;
                     ram_addr  <= ram_word;
                     ram_wdata <= bus.dWriteData;
                  end else begin
                     // MMIO: counter writes are silently dropped.
                     state         <= DONE;
                     bus.mem_ready <= 1'b1;
                     if (bus.MemRead) bus.dReadData <= mmio_rdata;
`ifdef DMEM_MMIO_EN
                     else if (hit_led) led_reg <= bus.dWriteData;
`endif
                  end
               end
            end
            ISSUE: begin
               if (ram_we) begin
                  state         <= DONE;
                  bus.mem_ready <= 1'b1;
               end else begin
                  state    <= WAIT;
                  wait_cnt <= LAT_M1;
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  bus.dReadData <= ram_rdata;
                  bus.mem_ready <= 1'b1;
                  state         <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            DONE: begin
               // A held strobe must not start a second access.
               if (!req) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge with a behavioural fixed-latency RAM.
module tb_dmem_bridge;

   localparam int AW  = 10;
   localparam int LAT = 2;

   logic          clk;
   logic          rst;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   logic [31:0]   led_out;

   int checks   = 0;
   int failures = 0;
   int ram_en_count = 0;
   int ready_count  = 0;

   logic [31:0] c1;
   logic [31:0] c2;

   dmem_bridge_if bus ();

   dmem_bridge #(
      .RAM_BASE   (32'h1001_0000),
      .RAM_WORDS  (1024),
      .RAM_LATENCY(LAT),
      .MMIO_BASE  (32'hFFFF_0000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .ram_en   (ram_en),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .led_out  (led_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: data read at the ram_en edge appears LAT cycles after the ram_en cycle.
   logic [31:0] ram_mem [0:1023];
   logic [31:0] pipe [0:LAT-1];

   always @(posedge clk) begin
      if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
      pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : 32'hBAD0_BAD0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_rdata = pipe[LAT-1];

   always @(negedge clk) begin
      if (ram_en) ram_en_count++;
      if (bus.mem_ready) ready_count++;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Called just after a negedge; T0 is the next posedge, k counts cycles T0+k.
   task automatic apply_stimulus(input string tag, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int exp_cyc, input logic exp_err,
                                 input logic chk_data, input logic [31:0] exp_data,
                                 input int exp_en, input logic [AW-1:0] exp_word, input int hold);
      int k;
      int en0;
      int rdy0;
      en0  = ram_en_count;
      rdy0 = ready_count;
      bus.MemRead    = rd;
      bus.MemWrite   = wr;
      bus.dAddress   = addr;
      bus.dWriteData = wdata;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            check_output({tag, " ram_en@T0+1"}, 32'(ram_en), 32'(exp_en == 1));
            if (exp_en == 1) begin
               check_output({tag, " ram_addr"}, 32'(ram_addr), 32'(exp_word));
               check_output({tag, " ram_we"}, 32'(ram_we), 32'(wr));
               if (wr) check_output({tag, " ram_wdata"}, ram_wdata, wdata);
            end
            bus.dAddress   = addr ^ 32'h0BAD_0BAD;
            bus.dWriteData = ~wdata;
         end
      end while (!bus.mem_ready && k < 40);
      check_output({tag, " ready cycle"}, 32'(k), 32'(exp_cyc));
      check_output({tag, " mem_err"}, 32'(bus.mem_err), 32'(exp_err));
      if (chk_data) check_output({tag, " dReadData"}, bus.dReadData, exp_data);
      repeat (hold) @(negedge clk);
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      @(negedge clk);
      #1;
      check_output({tag, " ram_en pulses"}, 32'(ram_en_count - en0), 32'(exp_en));
      check_output({tag, " ready pulses"}, 32'(ready_count - rdy0), 32'd1);
   endtask

   initial begin
      rst            = 1'b1;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.dAddress   = '0;
      bus.dWriteData = '0;
      repeat (3) @(negedge clk);
      check_output("reset dReadData", bus.dReadData, 32'h0);
      check_output("reset mem_ready", 32'(bus.mem_ready), 32'h0);
      check_output("reset mem_err", 32'(bus.mem_err), 32'h0);
      check_output("reset ram_en", 32'(ram_en), 32'h0);
      check_output("reset ram_we", 32'(ram_we), 32'h0);
      check_output("reset ram_addr", 32'(ram_addr), 32'h0);
      check_output("reset ram_wdata", ram_wdata, 32'h0);
      check_output("reset led_out", led_out, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      #1;

      $display("[TB] RAM write/read");
      apply_stimulus("wr 08", 1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 2, 1'b0, 1'b0, 32'h0, 1, 10'd2, 0);
      apply_stimulus("rd 08 held", 1'b1, 1'b0, 32'h1001_0008, 32'h0, 2 + LAT, 1'b0, 1'b1, 32'hDEAD_BEEF, 1, 10'd2, 6);

      $display("[TB] error decodes");
      apply_stimulus("rd misaligned", 1'b1, 1'b0, 32'h1001_0002, 32'h0, 1, 1'b1, 1'b1, 32'h0, 0, 10'd0, 0);
      apply_stimulus("wr top word", 1'b0, 1'b1, 32'h1001_0FFC, 32'h1234_5678, 2, 1'b0, 1'b0, 32'h0, 1, 10'd1023, 0);
      apply_stimulus("rd top word", 1'b1, 1'b0, 32'h1001_0FFC, 32'h0, 2 + LAT, 1'b0, 1'b1, 32'h1234_5678, 1, 10'd1023, 0);
      apply_stimulus("rd unmapped", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1, 1'b1, 1'b1, 32'h0, 0, 10'd0, 0);
      apply_stimulus("both strobes", 1'b1, 1'b1, 32'h1001_0000, 32'h0, 1, 1'b1, 1'b0, 32'h0, 0, 10'd0, 0);
      apply_stimulus("wr past ram", 1'b0, 1'b1, 32'h1001_1000, 32'h5555_5555, 1, 1'b1, 1'b0, 32'h0, 0, 10'd0, 0);

`ifdef DMEM_MMIO_EN
      $display("[TB] MMIO enabled");
      apply_stimulus("wr led", 1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_005A, 1, 1'b0, 1'b0, 32'h0, 0, 10'd0, 0);
      check_output("led_out", led_out, 32'h0000_005A);
      apply_stimulus("rd led", 1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 1, 1'b0, 1'b1, 32'h0000_005A, 0, 10'd0, 0);
      apply_stimulus("wr counter", 1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_0099, 1, 1'b0, 1'b0, 32'h0, 0, 10'd0, 0);
      apply_stimulus("rd counter 1", 1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 1, 1'b0, 1'b0, 32'h0, 0, 10'd0, 0);
      c1 = bus.dReadData;
      repeat (8) @(negedge clk);
      #1;
      apply_stimulus("rd counter 2", 1'b1, 1'b0, 32'hFFFF_0004, 32'h0, 1, 1'b0, 1'b0, 32'h0, 0, 10'd0, 0);
      c2 = bus.dReadData;
      check_output("counter delta", c2 - c1, 32'd10);
`else
      $display("[TB] MMIO disabled");
      apply_stimulus("wr led off", 1'b0, 1'b1, 32'hFFFF_0000, 32'h0000_005A, 1, 1'b1, 1'b0, 32'h0, 0, 10'd0, 0);
      apply_stimulus("wr counter off", 1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_0099, 1, 1'b1, 1'b0, 32'h0, 0, 10'd0, 0);
      check_output("led_out off", led_out, 32'h0);
`endif

      $display("[TB] reset during WAIT");
      apply_stimulus("rd before rst", 1'b1, 1'b0, 32'h1001_0008, 32'h0, 2 + LAT, 1'b0, 1'b1, 32'hDEAD_BEEF, 1, 10'd2, 0);
      bus.MemRead  = 1'b1;
      bus.dAddress = 32'h1001_0008;
      @(negedge clk);
      @(negedge clk);
      check_output("state WAIT", 32'(dut.state), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      check_output("rst state", 32'(dut.state), 32'd0);
      check_output("rst dReadData", bus.dReadData, 32'h0);
      check_output("rst mem_ready", 32'(bus.mem_ready), 32'h0);
      check_output("rst mem_err", 32'(bus.mem_err), 32'h0);
      check_output("rst ram_en", 32'(ram_en), 32'h0);
      check_output("rst ram_addr", 32'(ram_addr), 32'h0);
      check_output("rst led_out", led_out, 32'h0);
      rst          = 1'b0;
      bus.MemRead  = 1'b0;
      @(negedge clk);
      #1;
      apply_stimulus("rd after rst", 1'b1, 1'b0, 32'h1001_0008, 32'h0, 2 + LAT, 1'b0, 1'b1, 32'hDEAD_BEEF, 1, 10'd2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the multicycle RV32I core's MEM-stage strobes (MemRead/MemWrite, dAddress, dWriteData) and a synchronous data RAM with fixed read latency. It decodes the address into RAM, MMIO or unmapped space, issues a single RAM access per request, returns read data with a one-cycle `mem_ready` pulse, and flags illegal requests on `mem_err`. The core's MEM state stalls on `mem_ready`.

## Interface
- RAM_BASE, 32'h10010000, byte address of RAM word 0
- RAM_WORDS, 1024, RAM depth in 32-bit words (power of two)
- RAM_LATENCY, 2, cycles from `ram_en` cycle to valid `ram_rdata` (1..15)
- MMIO_BASE, 32'hFFFF0000, base of the 8-byte MMIO window

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- MemRead  in  1  core read strobe, held until `mem_ready`
- MemWrite  in  1  core write strobe, held until `mem_ready`
- dAddress  in  32  byte address
- dWriteData  in  32  store data
- dReadData  out  32  load data, registered
- mem_ready  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle error pulse, coincident with `mem_ready`
- ram_en  out  1  RAM access strobe, one cycle per access
- ram_we  out  1  RAM write enable, qualified by `ram_en`
- ram_addr  out  $clog2(RAM_WORDS)  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data
- led_out  out  32  MMIO LED register

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: request accepted when MemRead|MemWrite sampled high. Decode at acceptance:
  - both strobes high, or dAddress[1:0]≠0 → error: DONE, mem_err=1, no RAM access.
  - RAM_BASE ≤ addr < RAM_BASE+4·RAM_WORDS (unsigned, 33-bit compare, no wrap) → ISSUE; ram_addr=(addr−RAM_BASE)>>2, ram_we=MemWrite, ram_wdata=dWriteData latched.
  - MMIO_BASE+0: LED register, R/W. MMIO_BASE+4: free-running 32-bit cycle counter, read-only; writes ignored without error. Other MMIO-window addresses → error. MMIO completes straight to DONE.
  - anything else → error, DONE.
- ISSUE: ram_en=1 for exactly one cycle. Write → DONE. Read → WAIT with down-counter loaded with RAM_LATENCY−1.
- WAIT: counter decrements; at 0, dReadData←ram_rdata, → DONE.
- DONE: mem_ready (and mem_err if error) high in the first DONE cycle only. Stays in DONE while either strobe is high; → IDLE when both low. No second access from a held strobe.
- dReadData updates only on successful reads (RAM or MMIO); error reads load 0. Holds value otherwise.
- Cycle counter increments every cycle including during requests; wraps 32'hFFFFFFFF→0.

## Timing
- Reset: state IDLE; dReadData, mem_ready, mem_err, ram_en, ram_we, ram_addr, ram_wdata, led_out, cycle counter = 0. rst has priority over all, aborts any in-flight access; ram_en low from the cycle after rst sampled.
- Acceptance edge = T0. RAM write: ram_en in T0+1, mem_ready in T0+2. RAM read: ram_en in T0+1, ram_rdata sampled at end of cycle T0+1+RAM_LATENCY, dReadData/mem_ready valid in T0+2+RAM_LATENCY.
- MMIO and errors: mem_ready in T0+1; LED write visible on led_out in T0+1.
- Counter read returns value at T0 edge.
- dAddress/dWriteData may change after T0; bridge uses latched values.
- Earliest next acceptance: edge after strobes sampled low in DONE.

## Configuration
- `DMEM_MMIO_EN` defined: MMIO window, LED register and cycle counter as above.
- Not defined: MMIO window decodes as unmapped (error); led_out tied to 0; no counter logic. RAM path unchanged.

## Test plan
- Reset, then write 0xDEADBEEF to 0x10010008, read back → ram_en T0+1 with ram_addr=2, ram_we=1; read mem_ready at T0+4, dReadData=0xDEADBEEF, mem_err=0.
- Strobe held 6 cycles after mem_ready → exactly one ram_en pulse, one mem_ready pulse.
- Read 0x10010002 (misaligned) and 0x00000000 (unmapped) → mem_ready+mem_err at T0+1, dReadData=0, no ram_en.
- Both strobes high at 0x10010000 → error, no RAM access; RAM_WORDS boundary 0x10011000 → error, 0x10010FFC → RAM word 1023.
- With DMEM_MMIO_EN: write 0x5A to 0xFFFF0000 → led_out=0x5A at T0+1; write 0xFFFF0004 → no error; two counter reads 10 edges apart differ by 10. Without macro: both → mem_err.
- Assert rst in WAIT of a read → next cycle all outputs 0, state IDLE; subsequent read of same address completes normally.
